// File: rtl/genius_pkg.sv
// Shared types and constants for the genius game sequence store.
// Enums, sizes, LFSR constants, choice codes and the fixed pattern.
package genius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int         SEQ_LEN           = 16;
    localparam logic [3:0] SEQ_LAST          = 4'(SEQ_LEN - 1);
    localparam logic [7:0] LFSR_POLY         = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

    localparam logic [1:0] CHOICE_BTN0 = 2'd0;
    localparam logic [1:0] CHOICE_BTN1 = 2'd1;
    localparam logic [1:0] CHOICE_BTN2 = 2'd2;
    localparam logic [1:0] CHOICE_SKIP = 2'd3;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? LFSR_POLY : 8'h00);
    endfunction

    function automatic logic [1:0] fixed_choice(input logic [3:0] idx);
        logic [1:0] c;
        c = CHOICE_BTN0;
        case (idx)
            4'd0:  c = CHOICE_BTN2;
            4'd1:  c = CHOICE_BTN1;
            4'd3:  c = CHOICE_BTN1;
            4'd5:  c = CHOICE_BTN2;
            4'd7:  c = CHOICE_BTN2;
            4'd9:  c = CHOICE_BTN1;
            4'd11: c = CHOICE_BTN2;
            4'd13: c = CHOICE_BTN1;
            4'd15: c = CHOICE_BTN1;
            default: c = CHOICE_BTN0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit right-shifting Galois LFSR with synchronous load and step.
// Load wins over step; state resets to the default seed.
module lfsr8
    import genius_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state <= load_value;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sequence_writer.sv
// Fills a 16x2 choice store from an LFSR on each start rising edge.
// Define SEQ_FIXED_PATTERN_EN to write a fixed pattern instead.
module sequence_writer
    import genius_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic [3:0] rd_addr,
    output logic [1:0] rd_data,
    output logic       busy,
    output logic       ready
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       start_q;
    logic       start_edge;
    logic [3:0] wr_ptr_q;
    logic [3:0] wr_ptr_d;
    logic       busy_d;
    logic       ready_d;
    logic       we;
    logic       wr_ok;
    logic [1:0] wdata;
    logic       lfsr_load;
    logic       lfsr_step;
    logic [1:0] mem [SEQ_LEN];

    assign start_edge = start & ~start_q;

`ifdef SEQ_FIXED_PATTERN_EN
    logic seed_unused;
    logic lfsr_unused;

    assign seed_unused = ^seed;
    assign lfsr_unused = lfsr_load ^ lfsr_step;
    assign wdata       = fixed_choice(wr_ptr_q);
    assign wr_ok       = 1'b1;
`else
    logic [7:0] lfsr_state;
    logic [5:0] lfsr_unused;
    logic [7:0] lfsr_seed;

    // A zero seed would lock the LFSR at zero forever.
    assign lfsr_seed   = (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
    assign lfsr_unused = lfsr_state[7:2];
    assign wdata       = lfsr_state[1:0];
    assign wr_ok       = (wdata != CHOICE_SKIP);

    lfsr8 u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (lfsr_load),
        .load_value (lfsr_seed),
        .step       (lfsr_step),
        .state      (lfsr_state)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b1;
            wr_ptr_q <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            wr_ptr_q <= wr_ptr_d;
            busy     <= busy_d;
            ready    <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        busy_d    = busy;
        ready_d   = ready;
        we        = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (start_edge) begin
            lfsr_load = 1'b1;
            state_d   = FILL;
            wr_ptr_d  = '0;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
        end else if (state_q == FILL) begin
            lfsr_step = 1'b1;
            if (wr_ok) begin
                we = 1'b1;
                if (wr_ptr_q == SEQ_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Same-cycle read of the entry being written returns the old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sequence_writer.sv
// Directed and randomized checks of sequence_writer against a
// behavioural model of the fill sequence.
module tb_sequence_writer;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] seed;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy;
    logic       ready;

    int checks;
    int errors;

    logic [1:0] m_vals [16];
    int         m_cycles;
    int         m_at7;
    logic [1:0] pat [16] = '{2, 1, 0, 1, 0, 2, 0, 2, 0, 1, 0, 2, 0, 1, 0, 1};

    sequence_writer dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .seed    (seed),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .ready   (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected store and fill duration, straight from the fill rules.
    task automatic model(input logic [7:0] s);
        int l;
        int n;
        int c;
        m_at7 = -1;
`ifdef SEQ_FIXED_PATTERN_EN
        for (int i = 0; i < 16; i++) m_vals[i] = pat[i];
        m_cycles = 16;
        m_at7    = 7;
        l = int'(s);
`else
        l = int'(s);
        n = 0;
        c = 0;
        while (n < 16) begin
            if (l % 4 != 3) begin
                m_vals[n] = 2'(l % 4);
                n++;
                if (n == 7) m_at7 = c + 1;
            end
            c++;
            l = (l / 2) ^ ((l % 2 == 1) ? 'hB8 : 0);
        end
        m_cycles = c;
`endif
    endtask

    task automatic do_start(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_ready", int'(ready), 0);
    endtask

    task automatic wait_ready(input bit mon, input logic [1:0] old15);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            tick();
            n++;
            if (mon) chk("rd15_old", int'(rd_data), int'(old15));
        end
        chk("fill_cycles", n, m_cycles);
        chk("done_busy", int'(busy), 0);
    endtask

    task automatic read_check(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            chk(tag, int'(rd_data), int'(m_vals[a]));
        end
    endtask

    initial begin
        logic [7:0] s;
        logic [1:0] old15;
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        seed    = 8'h00;
        rd_addr = 4'd0;

        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_rd", int'(rd_data), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(ready), 0);
        for (int i = 0; i < 16; i++) m_vals[i] = 2'd0;
        read_check("rst_store");

        model(8'h01);
        do_start(8'h01);
        wait_ready(1'b0, 2'd0);
        chk("ready_hi", int'(ready), 1);
        seed = 8'h5A;
        repeat (3) tick();
        read_check("seed01_store");
`ifndef SEQ_FIXED_PATTERN_EN
        for (int a = 0; a < 4; a++) begin
            rd_addr = 4'(a);
            tick();
            chk("seed01_head", int'(rd_data), (a == 0) ? 1 : (a == 3) ? 2 : 0);
        end
`endif
        chk("done_ready_hold", int'(ready), 1);

        model(8'hA5);
        do_start(8'h00);
        wait_ready(1'b0, 2'd0);
        read_check("seed00_store");
        do_start(8'hA5);
        wait_ready(1'b0, 2'd0);
        read_check("seedA5_store");

        s = 8'($urandom_range(1, 255));
        model(s);
        do_start(s);
        repeat (m_at7) tick();
        chk("mid_busy", int'(busy), 1);
        chk("mid_ready", int'(ready), 0);
        s = 8'($urandom_range(1, 255));
        model(s);
        do_start(s);
        wait_ready(1'b0, 2'd0);
        read_check("restart_store");

        s = 8'($urandom_range(1, 255));
        model(s);
        do_start(s);
        repeat (5) tick();
        start = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ready), 0);
        chk("abort_rd", int'(rd_data), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (40) tick();
        chk("held_busy", int'(busy), 0);
        chk("held_ready", int'(ready), 0);
        for (int i = 0; i < 16; i++) m_vals[i] = 2'd0;
        read_check("abort_store");
        chk("held_busy2", int'(busy), 0);
        start = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            s     = 8'($urandom_range(1, 255));
            old15 = m_vals[15];
            model(s);
            rd_addr = 4'd15;
            do_start(s);
            wait_ready(1'b1, old15);
            tick();
            chk("rd15_new", int'(rd_data), int'(m_vals[15]));
            read_check("rand_store");
        end

`ifdef SEQ_FIXED_PATTERN_EN
        rd_addr = 4'd5;
        tick();
        chk("fixed_rd5", int'(rd_data), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
